// File: rtl/spi_pkg.sv
// Shared SPI frame constants, state encoding and frame payload type.
// Reused by the on-chip peripheral-side decode.
package spi_pkg;

  localparam int unsigned FRAME_BITS   = 16;
  localparam int unsigned ADDR_BITS    = 7;
  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned CNT_BITS     = 8;
  localparam int unsigned BIT_CNT_BITS = 5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOW  = 3'd1,
    HIGH = 3'd2,
    HOLD = 3'd3,
    GAP  = 3'd4
  } spi_state_e;

  typedef struct packed {
    logic                 write;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } spi_frame_t;

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module spi_phase_timer
  import spi_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CNT_BITS-1:0] load_val,
  output logic                expire
);

  logic [CNT_BITS-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_BITS'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one {write, addr, data} frame MSB-first.
// Define SPI_CTRL_CIPO_EN to add cipo capture into rdata during the data byte.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_data,
  output logic                 sclk,
  output logic                 copi,
  output logic                 ncs,
  output logic                 busy,
  output logic                 done
`ifdef SPI_CTRL_CIPO_EN
  ,
  input  logic                 cipo,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_valid
`endif
);

  localparam logic [CNT_BITS-1:0]     DIV_LOAD = CNT_BITS'(CLK_DIV - 1);
  localparam logic [CNT_BITS-1:0]     GAP_LOAD = CNT_BITS'(GAP_CYCLES - 1);
  localparam logic [BIT_CNT_BITS-1:0] LAST_BIT = BIT_CNT_BITS'(FRAME_BITS - 1);

  spi_state_e              state;
  logic [FRAME_BITS-1:0]   shreg;
  logic [BIT_CNT_BITS-1:0] bit_cnt;
  spi_frame_t              frame_c;
  logic                    accept_c;
  logic                    expire;
  logic                    tmr_load_c;
  logic [CNT_BITS-1:0]     tmr_val_c;

  assign accept_c = req_valid && req_ready;
  assign frame_c  = '{write: req_write, addr: req_addr, data: req_data};
  // copi is the shift register MSB; clearing the register drives copi low in GAP
  assign copi     = shreg[FRAME_BITS-1];

  a_clk_div_legal: assert property (@(posedge clk) CLK_DIV >= 2);

  // Phase length selection: every phase reloads on entry, GAP uses its own length
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = DIV_LOAD;
    unique case (state)
      IDLE:      tmr_load_c = accept_c;
      LOW, HIGH: tmr_load_c = expire;
      HOLD: begin
        tmr_load_c = expire;
        tmr_val_c  = GAP_LOAD;
      end
      default:   tmr_load_c = 1'b0;
    endcase
  end

  spi_phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .expire   (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sclk      <= 1'b0;
      ncs       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            shreg     <= frame_c;
            ncs       <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            state     <= LOW;
          end
        end
        LOW: begin
          if (expire) begin
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          if (expire) begin
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt + BIT_CNT_BITS'(1);
            if (bit_cnt == LAST_BIT) begin
              state <= HOLD;
            end else begin
              shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
              state <= LOW;
            end
          end
        end
        HOLD: begin
          if (expire) begin
            ncs   <= 1'b1;
            shreg <= '0;
            done  <= 1'b1;
            state <= GAP;
          end
        end
        GAP: begin
          if (expire) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            bit_cnt   <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_CTRL_CIPO_EN
  logic rise_q;

  // rise_q marks the first HIGH cycle; only the data-byte bits shift into rdata
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_q      <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rise_q      <= (state == LOW) && expire;
      rdata_valid <= (state == HOLD) && expire;
      if (rise_q && (bit_cnt >= BIT_CNT_BITS'(FRAME_BITS - DATA_BITS))) begin
        rdata <= {rdata[DATA_BITS-2:0], cipo};
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: frame-level timing model checked every cycle on a
// CLK_DIV=4 and a CLK_DIV=2 instance, plus directed literal expectations.
module tb_spi_controller;

  localparam int D1 = 4;
  localparam int D2 = 2;
  localparam int G  = 4;
  localparam logic [7:0] RESP = 8'h3C;

  typedef struct packed {
    logic ready;
    logic busy;
    logic ncs;
    logic sclk;
    logic copi;
    logic done;
  } pins_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_valid2 = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = 7'h00;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, sclk, copi, ncs, busy, done;
  logic       req_ready2, sclk2, copi2, ncs2, busy2, done2;
`ifdef SPI_CTRL_CIPO_EN
  logic       cipo = 1'b0;
  logic [7:0] rdata, rdata2;
  logic       rdata_valid, rdata_valid2;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // frame-level model state per instance
  bit          m_act   [2] = '{0, 0};
  int          m_start [2] = '{0, 0};
  logic [15:0] m_frame [2] = '{16'h0, 16'h0};
  int          acc_q[$];

  // observed events on the CLK_DIV=4 instance
  int          done_cnt1 = 0, done_cyc1 = 0, fall_cyc1 = 0, ready_cyc1 = 0, rises1 = 0;
  logic [15:0] rx1 = 16'h0;
  logic        prev_ncs1 = 1'b1, prev_sclk1 = 1'b0, prev_ready1 = 1'b1;
  // CLK_DIV=2 instance phase measurement
  int          run2 = 0, low2 = 0;
  logic        prev_sclk2 = 1'b0, prev_copi2 = 1'b0, pend2 = 1'b0, pend_val2 = 1'b0;

  always #5 clk = ~clk;

  spi_controller #(.CLK_DIV(D1), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .sclk(sclk), .copi(copi), .ncs(ncs), .busy(busy), .done(done)
`ifdef SPI_CTRL_CIPO_EN
    , .cipo(cipo), .rdata(rdata), .rdata_valid(rdata_valid)
`endif
  );

  spi_controller #(.CLK_DIV(D2), .GAP_CYCLES(G)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
    .sclk(sclk2), .copi(copi2), .ncs(ncs2), .busy(busy2), .done(done2)
`ifdef SPI_CTRL_CIPO_EN
    , .cipo(1'b0), .rdata(rdata2), .rdata_valid(rdata_valid2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pin values t cycles after an accept: 32 bit-halves of div cycles, div hold, gap idle-high
  function automatic pins_t model(input int div, input bit act, input int t, input logic [15:0] f);
    pins_t p;
    int    k;
    p.ready = 1'b1; p.busy = 1'b0; p.ncs = 1'b1; p.sclk = 1'b0; p.copi = 1'b0; p.done = 1'b0;
    if (act && t >= 1 && t <= 33 * div + G) begin
      p.ready = 1'b0;
      p.busy  = 1'b1;
      if (t <= 32 * div) begin
        k      = (t - 1) / (2 * div);
        p.ncs  = 1'b0;
        p.sclk = ((t - 1) % (2 * div)) >= div;
        p.copi = f[15 - k];
      end else if (t <= 33 * div) begin
        p.ncs  = 1'b0;
        p.copi = f[0];
      end else begin
        p.done = (t == 33 * div + 1);
      end
    end
    return p;
  endfunction

  // Model update: accept whenever the model says the instance is idle
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0;
      end else if (((i == 0) ? req_valid : req_valid2) &&
                   (!m_act[i] || (cyc - m_start[i]) > 33 * ((i == 0) ? D1 : D2) + G)) begin
        m_act[i]   = 1'b1;
        m_start[i] = cyc;
        m_frame[i] = {req_write, req_addr, req_data};
        if (i == 0) acc_q.push_back(cyc);
      end
    end
    cyc = cyc + 1;
  end

  // Per-cycle compare plus event capture
  always @(negedge clk) begin
    pins_t e1, e2, a1, a2;
    int    t1;
    e1 = model(D1, m_act[0], cyc - m_start[0], m_frame[0]);
    e2 = model(D2, m_act[1], cyc - m_start[1], m_frame[1]);
    a1 = {req_ready, busy, ncs, sclk, copi, done};
    a2 = {req_ready2, busy2, ncs2, sclk2, copi2, done2};
    chk("div4_pins{ready,busy,ncs,sclk,copi,done}", 32'(a1), 32'(e1));
    chk("div2_pins{ready,busy,ncs,sclk,copi,done}", 32'(a2), 32'(e2));
`ifdef SPI_CTRL_CIPO_EN
    chk("rdata_valid_with_done", 32'(rdata_valid), 32'(e1.done));
    if (e1.done) chk("rdata_loopback", 32'(rdata), 32'(RESP));
    if (e2.done) chk("rdata2_zero", 32'(rdata2), 32'h0);
`endif

    if (done) begin done_cnt1++; done_cyc1 = cyc; end
    if (!ncs && prev_ncs1) fall_cyc1 = cyc;
    if (req_ready && !prev_ready1) ready_cyc1 = cyc;
    if (sclk && !prev_sclk1) begin rx1 = {rx1[14:0], copi}; rises1++; end
    prev_ncs1 = ncs; prev_sclk1 = sclk; prev_ready1 = req_ready;

    if (pend2) begin
      chk("div2_copi_after_rise", 32'(copi2), 32'(pend_val2));
      pend2 = 1'b0;
    end
    if (ncs2) begin
      run2 = 0;
    end else if (sclk2 != prev_sclk2 && run2 > 0) begin
      chk(sclk2 ? "div2_low_phase_len" : "div2_high_phase_len", 32'(run2), 32'(D2));
      run2 = 1;
    end else begin
      run2++;
    end
    if (!ncs2 && sclk2 && !prev_sclk2) begin
      chk("div2_copi_before_rise", 32'(copi2), 32'(prev_copi2));
      pend2 = 1'b1;
      pend_val2 = copi2;
    end
    if (!ncs2) low2++;
    if (done2) chk("div2_ncs_low_cycles", 32'(low2), 32'd66);
    if (ncs2) low2 = 0;
    prev_sclk2 = sclk2; prev_copi2 = copi2;

`ifdef SPI_CTRL_CIPO_EN
    t1 = cyc - m_start[0];
    cipo = 1'b0;
    if (m_act[0] && t1 >= 1 && t1 <= 32 * D1 && (t1 - 1) / (2 * D1) >= 8)
      cipo = RESP[15 - (t1 - 1) / (2 * D1)];
`else
    t1 = 0;
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_accepts(input int target, input int budget, input string name);
    int n = 0;
    while (acc_q.size() < target && n < budget) begin step(); n++; end
    chk(name, 32'(acc_q.size()), 32'(target));
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt1 < target && n < budget) begin step(); n++; end
    chk(name, 32'(done_cnt1), 32'(target));
  endtask

  initial begin
    int a0, d0, n;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_ncs", 32'(ncs), 32'd1);
    chk("rst_sclk_copi", 32'({sclk, copi}), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic write 0x84A5 on both instances, inputs scrambled after accept
    rx1 = 16'h0; rises1 = 0;
    req_write = 1'b1; req_addr = 7'h04; req_data = 8'hA5;
    req_valid = 1'b1; req_valid2 = 1'b1;
    wait_accepts(1, 4, "accept_a");
    req_valid = 1'b0; req_valid2 = 1'b0;
    req_write = 1'b0; req_addr = 7'h55; req_data = 8'h0F;
    wait_done(1, 200, "done_a");
    chk("a_frame_bits", 32'(rx1), 32'h84A5);
    chk("a_rise_count", 32'(rises1), 32'd16);
    chk("a_ncs_fall_cycle", 32'(fall_cyc1 - acc_q[0]), 32'd1);
    chk("a_done_cycle", 32'(done_cyc1 - acc_q[0]), 32'd133);
    repeat (6) step();
    chk("a_ready_cycle", 32'(ready_cyc1 - acc_q[0]), 32'd137);

    // Back-to-back: valid held high across two requests
    a0 = acc_q.size(); d0 = done_cnt1; rx1 = 16'h0;
    req_write = 1'b0; req_addr = 7'h12; req_data = 8'h3C; req_valid = 1'b1;
    wait_accepts(a0 + 1, 4, "accept_b");
    req_write = 1'b1; req_addr = 7'h7E; req_data = 8'hC3;
    wait_accepts(a0 + 2, 200, "accept_c");
    req_valid = 1'b0;
    chk("b2b_accept_spacing", 32'(acc_q[a0 + 1] - acc_q[a0]), 32'd137);
    chk("b_frame_bits", 32'(rx1), 32'h123C);
    rx1 = 16'h0;
    wait_done(d0 + 2, 200, "done_c");
    chk("c_frame_bits", 32'(rx1), 32'hFEC3);
    repeat (10) step();
    chk("b2b_done_total", 32'(done_cnt1 - d0), 32'd2);
    chk("b2b_no_extra_accept", 32'(acc_q.size()), 32'(a0 + 2));

    // Reset at cycle 60 of a frame, then a clean frame
    a0 = acc_q.size(); d0 = done_cnt1;
    req_write = 1'b1; req_addr = 7'h2A; req_data = 8'h5A; req_valid = 1'b1;
    wait_accepts(a0 + 1, 4, "accept_d");
    req_valid = 1'b0;
    n = 0;
    while (cyc - acc_q[a0] < 60 && n < 100) begin step(); n++; end
    chk("d_reached_cycle_60", 32'(cyc - acc_q[a0]), 32'd60);
    rst_n = 1'b0;
    step();
    chk("midrst_ncs", 32'(ncs), 32'd1);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("midrst_no_done", 32'(done_cnt1), 32'(d0));
    rx1 = 16'h0;
    req_write = 1'b0; req_addr = 7'h7F; req_data = 8'h01; req_valid = 1'b1;
    wait_accepts(a0 + 2, 4, "accept_e");
    req_valid = 1'b0;
    wait_done(d0 + 1, 200, "done_e");
    chk("e_frame_bits", 32'(rx1), 32'h7F01);
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
